// File: rtl/hf_tans_pkg.sv
// Shared types, sizes and default tables for the Huffman->tANS stream recoder.
package hf_tans_pkg;

  localparam int NSYM     = 3;
  localparam int R        = 3;
  localparam int MAX_CODE = 3;

  localparam int L       = 1 << R;
  localparam int X_W     = R + 1;
  localparam int BTR_W   = $clog2(R + 1);
  localparam int SYM_W   = $clog2(NSYM);
  localparam int NODE_W  = MAX_CODE - 1;
  localparam int VAL_W   = (NODE_W > SYM_W) ? NODE_W : SYM_W;
  localparam int TREE_N  = 2 ** MAX_CODE;
  localparam int TREE_AW = MAX_CODE;

  // One tree entry = child reached from {node, bit}; value is a symbol on a leaf, else a node index.
  typedef struct packed {
    logic             leaf;
    logic             invalid;
    logic [VAL_W-1:0] value;
  } node_t;

  typedef node_t [TREE_N-1:0]         tree_t;
  typedef logic [NSYM-1:0][X_W-1:0]   freq_t;
  typedef logic [L-1:0][X_W-1:0]      enc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_FLUSH
  } state_t;

  function automatic node_t mk_node(logic leaf, logic invalid, int value);
    return '{leaf: leaf, invalid: invalid, value: VAL_W'(value)};
  endfunction

  function automatic enc_t enc_default();
    enc_t e;
    for (int i = 0; i < L; i++) e[i] = X_W'(L + i);
    return e;
  endfunction

  // Codes A=0, B=10, C=11: root is node 0, the '1' prefix is node 1, nodes 2..3 unused.
  localparam tree_t TREE_DEF = {
    mk_node(1'b0, 1'b1, 0), mk_node(1'b0, 1'b1, 0),
    mk_node(1'b0, 1'b1, 0), mk_node(1'b0, 1'b1, 0),
    mk_node(1'b1, 1'b0, 2), mk_node(1'b1, 1'b0, 1),
    mk_node(1'b0, 1'b0, 1), mk_node(1'b1, 1'b0, 0)
  };
  localparam freq_t FREQ_DEF = {X_W'(1), X_W'(2), X_W'(5)};
  localparam freq_t CUM_DEF  = {X_W'(7), X_W'(5), X_W'(0)};
  localparam enc_t  ENC_DEF  = enc_default();

endpackage

// File: rtl/hf_tans_recoder_stream_walker.sv
// Decode stage: walks the Huffman tree one bit per accepted beat and holds one decoded symbol.
module hf_tree_walker
  import hf_tans_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  tree_t            tree,
  input  logic             accept,
  input  logic             start,
  input  logic             bit_in,
  input  logic             last,
  input  logic             consume,
  output logic [SYM_W-1:0] sym,
  output logic             sym_v,
  output logic             err_evt
);

  logic [NODE_W-1:0] node_q;
  logic [NODE_W-1:0] node_cur;
  node_t             child;
  logic              drop_walk;

  always_comb begin
    node_cur  = start ? '0 : node_q;
    child     = tree[{node_cur, bit_in}];
    // A block that ends on an internal node loses its partial codeword.
    drop_walk = child.invalid || (!child.leaf && last);
    err_evt   = accept && drop_walk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      node_q <= '0;
      sym    <= '0;
      sym_v  <= 1'b0;
    end else begin
      if (consume || start) sym_v <= 1'b0;
      if (accept) begin
        if (drop_walk) begin
          node_q <= '0;
        end else if (child.leaf) begin
          node_q <= '0;
          sym    <= child.value[SYM_W-1:0];
          sym_v  <= 1'b1;
        end else begin
          node_q <= child.value[NODE_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/hf_tans_recoder_stream.sv
// Serial Huffman decoder feeding a tANS encoder, with handshakes, end-of-block flush and sticky error.
// Optional runtime table loading is enabled by defining TABLE_LOAD_EN.
module hf_tans_recoder_stream
  import hf_tans_pkg::*;
(
  input  logic             PHI,
  input  logic             RST,
  input  logic             I_F,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             i_stream,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [BTR_W-1:0] BTR,
  output logic [R-1:0]     o_stream,
  output logic             o_last,
  output logic [X_W-1:0]   final_state,
  output logic             err,
`ifdef TABLE_LOAD_EN
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [7:0]       cfg_addr,
  input  logic [15:0]      cfg_data,
`endif
  output state_t           fsm_state
);

  // Handshake: a beat moves on a rising edge where valid && ready; valid never waits for ready,
  // and a presented output beat stays unchanged until it is taken.

  state_t           state, state_n;
  tree_t            tree_r;
  freq_t            freq_r, cum_r;
  enc_t             enc_r;
  logic [X_W-1:0]   x;
  logic [SYM_W-1:0] sym;
  logic             sym_v, err_evt;
  logic             out_free, accept, start, fire, flush_load, flush_done;
  logic [X_W-1:0]   f, c, y, x_next;
  logic [BTR_W-1:0] nb;
  logic [R-1:0]     keep, idx;

`ifdef TABLE_LOAD_EN
  always_ff @(posedge PHI) begin
    if (RST) begin
      tree_r <= TREE_DEF;
      freq_r <= FREQ_DEF;
      cum_r  <= CUM_DEF;
      enc_r  <= ENC_DEF;
    end else if (cfg_we && state == ST_IDLE) begin
      case (cfg_sel)
        2'd0: if (cfg_addr < 8'(TREE_N)) tree_r[cfg_addr[TREE_AW-1:0]] <= node_t'(cfg_data[VAL_W+1:0]);
        2'd1: if (cfg_addr < 8'(NSYM)) freq_r[cfg_addr[SYM_W-1:0]] <= cfg_data[X_W-1:0];
        2'd2: if (cfg_addr < 8'(NSYM)) cum_r[cfg_addr[SYM_W-1:0]] <= cfg_data[X_W-1:0];
        default: if (cfg_addr < 8'(L)) enc_r[cfg_addr[R-1:0]] <= cfg_data[X_W-1:0];
      endcase
    end
  end
`else
  assign tree_r = TREE_DEF;
  assign freq_r = FREQ_DEF;
  assign cum_r  = CUM_DEF;
  assign enc_r  = ENC_DEF;
`endif

  hf_tree_walker u_walker (
    .clk     (PHI),
    .rst     (RST),
    .tree    (tree_r),
    .accept  (accept),
    .start   (start),
    .bit_in  (i_stream),
    .last    (i_last),
    .consume (fire),
    .sym     (sym),
    .sym_v   (sym_v),
    .err_evt (err_evt)
  );

  always_ff @(posedge PHI) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    out_free   = !o_valid || o_ready;
    i_ready    = (state != ST_FLUSH) && (!sym_v || out_free);
    accept     = i_valid && i_ready;
    // A bit arriving while idle opens a block exactly as if I_F were set.
    start      = accept && (I_F || state == ST_IDLE);
    fire       = sym_v && out_free && !start;
    flush_load = (state == ST_FLUSH) && !sym_v && out_free && !(o_valid && o_last);
    flush_done = o_valid && o_ready && o_last;
    state_n    = state;
    case (state)
      ST_IDLE:   if (accept) state_n = i_last ? ST_FLUSH : ST_DECODE;
      ST_DECODE: if (accept && i_last) state_n = ST_FLUSH;
      ST_FLUSH:  if (flush_done) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    f  = freq_r[sym];
    c  = cum_r[sym];
    nb = BTR_W'(R);
    for (int k = R; k >= 0; k--) begin
      if (({1'b0, x} >> k) < {f, 1'b0}) nb = BTR_W'(k);
    end
    y      = x >> nb;
    keep   = R'(x & ~({X_W{1'b1}} << nb));
    idx    = R'(c + y - f);
    x_next = enc_r[idx];
  end

  always_ff @(posedge PHI) begin
    if (RST) begin
      o_valid  <= 1'b0;
      BTR      <= '0;
      o_stream <= '0;
      o_last   <= 1'b0;
      x        <= X_W'(L);
      err      <= 1'b0;
    end else begin
      if (fire) begin
        o_valid  <= 1'b1;
        BTR      <= nb;
        o_stream <= keep;
        o_last   <= 1'b0;
        x        <= x_next;
      end else if (flush_load) begin
        o_valid  <= 1'b1;
        BTR      <= '0;
        o_stream <= '0;
        o_last   <= 1'b1;
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      if (start) begin
        x   <= X_W'(L);
        err <= err_evt;
      end else if (err_evt) begin
        err <= 1'b1;
      end
    end
  end

  assign final_state = x;
  assign fsm_state   = state;

endmodule

// File: tb/tb_hf_tans_recoder_stream.sv
// Randomised scoreboard bench for hf_tans_recoder_stream against a symbol-level tANS model.
module tb_hf_tans_recoder_stream;
  import hf_tans_pkg::*;

  logic       PHI = 1'b0;
  logic       RST, I_F, i_valid, i_stream, i_last, o_ready;
  logic       i_ready, o_valid, o_last, err;
  logic [1:0] BTR;
  logic [2:0] o_stream;
  logic [3:0] final_state;
  state_t     fsm_state;
`ifdef TABLE_LOAD_EN
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [7:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
`endif

  hf_tans_recoder_stream dut (
    .PHI         (PHI),
    .RST         (RST),
    .I_F         (I_F),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_stream    (i_stream),
    .i_last      (i_last),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .BTR         (BTR),
    .o_stream    (o_stream),
    .o_last      (o_last),
    .final_state (final_state),
    .err         (err),
`ifdef TABLE_LOAD_EN
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
`endif
    .fsm_state   (fsm_state)
  );

  always #5 PHI = ~PHI;

  // Beat word: {err (last beats only), last, nbits[1:0], bits[2:0], state[3:0]}
  localparam int EW = 11;
  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int ready_mode = 2;
  bit gaps_en = 0;
  int blk_sym[$];
  bit blk_partial;
  int m_freq[3] = '{5, 2, 1};
  int m_cum[3]  = '{0, 5, 7};
  int m_enc[8]  = '{8, 9, 10, 11, 12, 13, 14, 15};

  function automatic logic [EW-1:0] pack_beat(int e, int l, int b, int s, int fs);
    return {e[0], l[0], b[1:0], s[2:0], fs[3:0]};
  endfunction

  task automatic chk(string name, int act, int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  // Reference: symbols are renormalised then mapped through the state table, one beat each.
  task automatic push_expected();
    int x = 8;
    foreach (blk_sym[i]) begin
      int s, nb, nx;
      s  = blk_sym[i];
      nb = 0;
      while ((x >> nb) >= 2 * m_freq[s]) nb++;
      nx = m_enc[m_cum[s] + (x >> nb) - m_freq[s]];
      exp_q.push_back(pack_beat(0, 0, nb, x % (1 << nb), nx));
      x = nx;
    end
    exp_q.push_back(pack_beat(blk_partial, 1, 0, 0, x));
  endtask

  task automatic send_bit(input logic b, input logic f, input logic l);
    int t = 0;
    i_valid = 1'b1; i_stream = b; I_F = f; i_last = l;
    do begin
      @(negedge PHI);
      t++;
    end while (!i_ready && t < 300);
    if (!i_ready) begin
      tests++; fails++;
      $display("FAIL input_timeout: i_ready stayed %0d, expected 1", i_ready);
    end
    @(posedge PHI); #1;
    i_valid = 1'b0; I_F = 1'b0; i_last = 1'b0;
    if (gaps_en) repeat ($urandom_range(0, 2)) begin @(posedge PHI); #1; end
  endtask

  task automatic send_block(input logic first_flag);
    logic bits[$];
    push_expected();
    foreach (blk_sym[i]) begin
      bits.push_back(blk_sym[i] != 0);
      if (blk_sym[i] != 0) bits.push_back(blk_sym[i] == 2);
    end
    if (blk_partial) bits.push_back(1'b1);
    foreach (bits[i]) send_bit(bits[i], (i == 0) ? first_flag : 1'b0, i == bits.size() - 1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(negedge PHI); t++; end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
    end
    @(posedge PHI); #1;
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_i_ready"}, i_ready, 1);
    chk({tag, "_o_valid"}, o_valid, 0);
    chk({tag, "_btr"}, BTR, 0);
    chk({tag, "_o_stream"}, o_stream, 0);
    chk({tag, "_o_last"}, o_last, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_final_state"}, final_state, 8);
  endtask

  initial begin
    o_ready = 1'b1;
    forever begin
      @(posedge PHI); #1;
      case (ready_mode)
        0:       o_ready = ($urandom_range(0, 3) != 0);
        1:       o_ready = 1'b0;
        default: o_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops on every taken beat, and checks a stalled beat holds still.
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_beat;
  always @(negedge PHI) begin
    logic [EW-1:0] act, want;
    act = {o_last ? err : 1'b0, o_last, BTR, o_stream, final_state};
    if (RST) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests++;
        if (!o_valid || act !== prev_beat) begin
          fails++;
          $display("FAIL beat_stable: got valid=%0d beat=%h, expected valid=1 beat=%h", o_valid, act, prev_beat);
        end
      end
      if (o_valid && o_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_beat: got beat %h, expected none", act);
        end else begin
          want = exp_q.pop_front();
          if (act !== want) begin
            fails++;
            $display("FAIL beat: got err=%0d last=%0d btr=%0d bits=%0d x=%0d, expected err=%0d last=%0d btr=%0d bits=%0d x=%0d",
                     act[10], act[9], act[8:7], act[6:4], act[3:0], want[10], want[9], want[8:7], want[6:4], want[3:0]);
          end
        end
      end
      prev_stall = o_valid && !o_ready;
      prev_beat  = act;
    end
  end

  initial begin
    RST = 1'b1; I_F = 1'b0; i_valid = 1'b0; i_stream = 1'b0; i_last = 1'b0;
    repeat (3) @(posedge PHI);
    #1 RST = 1'b0;
    @(negedge PHI);
    check_reset("reset");
    @(posedge PHI); #1;

    // Single A: beat x 8->11, then flush
    blk_sym = '{0}; blk_partial = 0;
    send_block(1'b1);
    drain();

    // C then B: beats (3,0,15) and (2,3,14)
    blk_sym = '{2, 1}; blk_partial = 0;
    send_block(1'b1);
    drain();

    // Downstream stall: the skid fills and input back-pressures mid-block
    ready_mode = 1;
    blk_sym = '{2, 1, 0}; blk_partial = 0;
    fork
      send_block(1'b1);
      begin
        int seen = 0;
        repeat (8) begin
          @(negedge PHI);
          if (!i_ready && fsm_state == ST_DECODE) seen = 1;
        end
        ready_mode = 2;
        chk("stall_backpressure", seen, 1);
      end
    join
    drain();

    // Block ending mid-codeword, then a clean block clears the error
    blk_sym = '{}; blk_partial = 1;
    send_block(1'b1);
    drain();
    chk("err_sticky", err, 1);
    blk_sym = '{0}; blk_partial = 0;
    send_block(1'b1);
    drain();
    @(negedge PHI);
    chk("err_cleared", err, 0);
    @(posedge PHI); #1;

    // Reset in the middle of a block
    ready_mode = 1;
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    RST = 1'b1;
    @(posedge PHI); #1;
    RST = 1'b0;
    exp_q.delete();
    @(negedge PHI);
    check_reset("midreset");
    ready_mode = 2;
    @(posedge PHI); #1;
    blk_sym = '{0}; blk_partial = 0;
    send_block(1'b1);
    drain();

    // Random blocks, random gaps and downstream throttling
    gaps_en = 1;
    ready_mode = 0;
    for (int b = 0; b < 40; b++) begin
      int n;
      blk_sym.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) blk_sym.push_back($urandom_range(0, 2));
      blk_partial = ($urandom_range(0, 3) == 0);
      send_block($urandom_range(0, 1) == 1);
    end
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
